unary_ops: RTL and testbench
============================

# unary_ops

Registered bank of Verilog unary operators applied to one 4-bit operand. Each output is the operator result under Verilog unsigned/signed extension and context-width rules. Serves as a frontend regression block that pins down operator semantics (width extension, sign handling, reduction zero-extension) in compiled netlists.

## Interface
- Parameters: none. Widths are fixed: operand 4 bits, wide results 6 bits.
- Clock and reset are one clock with an asynchronous, active-low reset.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- a  in  4  operand; unsigned, or two's-complement where "signed" is stated
- not_, not_signed  out  4  ~a
- not_w  out  6  ~{2'b00,a}
- not_signed_w  out  6  ~{a[3],a[3],a}
- neg_, neg_signed  out  4  -a mod 16
- neg_w  out  6  -{2'b00,a} mod 64
- neg_signed_w  out  6  -sext6(a) mod 64
- pos_, pos_signed  out  4  a
- pos_w  out  6  zero-extended a
- pos_signed_w  out  6  sign-extended a
- reduce_and_, reduce_and_signed  out  4  {3'b0,&a}; reduce_and_bit  out  1  &a
- reduce_or_, reduce_or_signed  out  4  {3'b0,|a}; reduce_or_bit  out  1  |a
- reduce_bool_, reduce_bool_signed  out  4  {3'b0,(a!=0)}; reduce_bool_bit  out  1  (a!=0)
- reduce_xor_, reduce_xor_signed  out  4  {3'b0,^a}; reduce_xor_bit  out  1  ^a
- reduce_xor_bit_bit  out  1  ^a[0], which is a[0]
- reduce_xnor_, reduce_xnor_signed  out  4  {3'b0,~^a}; reduce_xnor_bit  out  1  ~^a
- reduce_xnor_bit_bit  out  1  ~a[0]
- logic_not_, logic_not_signed  out  4  {3'b0,(a==0)}; logic_not_bit  out  1  (a==0)

## Operation
- Extension and context:
  - The operand is extended to the output width before the operator is applied.
  - Unsigned results zero-extend; signed results sign-extend.
- Reduction and logical results:
  - These are 1-bit unsigned values, even for signed operands.
  - They zero-extend to 4 bits; they never sign-extend.
- Signed and unsigned 4-bit variants are bit-identical. Only the 6-bit variants differ.
- Negation wraps modulo 2^width. There is no saturation or overflow flag.
- Outputs carry no X. The block handles all 16 operand values.

## Timing
- The combinational results are captured in output registers on the rising edge of clk.
- Latency is 1 cycle: outputs reflect a sampled at the previous edge.
- While rst_n=0, every output is 0 asynchronously, including not_w and the reduce_xnor outputs.
- First valid result: the first rising edge after rst_n deasserts.
- Reset mid-operation: outputs clear immediately. No state other than the output registers exists.
- The register updates every cycle. There is no enable and no handshake.

## Structure
- Shared package unary_ops_pkg holds:
  - constants IN_W=4 and WIDE_W=6;
  - helper functions sext6 and zext6.
- One natural sub-module, unary_ops_comb: the purely combinational operator core, with a 4-bit input and the full output vector.
- The top level instantiates unary_ops_comb and the reset-clearable output register bank.

## Test plan
- Reset check: hold rst_n=0 with a=4'b1111 -> all outputs 0. Release rst_n, one edge -> results for 1111 appear.
- a=4'b0000:
  - not_=1111, not_w=111111, not_signed_w=111111
  - neg_* all 0
  - logic_not_=0001, reduce_xnor_=0001, reduce_or_bit=0
- a=4'b1111:
  - neg_=0001, neg_w=110001, neg_signed_w=000001
  - not_w=110000, not_signed_w=000000
  - pos_w=001111, pos_signed_w=111111
  - reduce_and_=0001, reduce_xor_bit=0, reduce_xnor_bit=1
- a=4'b1000:
  - neg_=1000, neg_w=111000, neg_signed_w=001000
  - pos_signed_w=111000, not_w=110111, not_signed_w=000111
  - reduce_xor_=0001, reduce_and_=0000, logic_not_bit=0
- a=4'b0101:
  - reduce_xor_bit=0, reduce_xor_bit_bit=1, reduce_xnor_bit_bit=0
  - reduce_bool_=0001, not_=1010
- Random sweep: 1000 pseudo-random operands from xorshift128 seed 1652613690, one per cycle.
  - Each output is compared to a reference model one cycle later.
  - The sweep asserts rst_n once mid-run, and outputs must read 0 during that assertion.

Source files
------------

// File: rtl/unary_ops_pkg.sv
// Shared widths, the result bundle and the extension helpers for the
// unary operator bank.
package unary_ops_pkg;

  localparam int IN_W   = 4;
  localparam int WIDE_W = 6;

  typedef struct packed {
    logic [IN_W-1:0]   not_;
    logic [IN_W-1:0]   not_signed;
    logic [WIDE_W-1:0] not_w;
    logic [WIDE_W-1:0] not_signed_w;
    logic [IN_W-1:0]   neg_;
    logic [IN_W-1:0]   neg_signed;
    logic [WIDE_W-1:0] neg_w;
    logic [WIDE_W-1:0] neg_signed_w;
    logic [IN_W-1:0]   pos_;
    logic [IN_W-1:0]   pos_signed;
    logic [WIDE_W-1:0] pos_w;
    logic [WIDE_W-1:0] pos_signed_w;
    logic [IN_W-1:0]   reduce_and_;
    logic [IN_W-1:0]   reduce_and_signed;
    logic              reduce_and_bit;
    logic [IN_W-1:0]   reduce_or_;
    logic [IN_W-1:0]   reduce_or_signed;
    logic              reduce_or_bit;
    logic [IN_W-1:0]   reduce_bool_;
    logic [IN_W-1:0]   reduce_bool_signed;
    logic              reduce_bool_bit;
    logic [IN_W-1:0]   reduce_xor_;
    logic [IN_W-1:0]   reduce_xor_signed;
    logic              reduce_xor_bit;
    logic              reduce_xor_bit_bit;
    logic [IN_W-1:0]   reduce_xnor_;
    logic [IN_W-1:0]   reduce_xnor_signed;
    logic              reduce_xnor_bit;
    logic              reduce_xnor_bit_bit;
    logic [IN_W-1:0]   logic_not_;
    logic [IN_W-1:0]   logic_not_signed;
    logic              logic_not_bit;
  } res_t;

  function automatic logic [WIDE_W-1:0] sext6(input logic [IN_W-1:0] v);
    return {{(WIDE_W-IN_W){v[IN_W-1]}}, v};
  endfunction

  function automatic logic [WIDE_W-1:0] zext6(input logic [IN_W-1:0] v);
    return {{(WIDE_W-IN_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/unary_ops_comb.sv
// Purely combinational operator core: every unary result for one operand.
module unary_ops_comb
  import unary_ops_pkg::*;
(
  input  logic [IN_W-1:0] a_i,
  output res_t            res_o
);

  logic andBit, orBit, xorBit;

  assign andBit = &a_i;
  assign orBit  = |a_i;
  assign xorBit = ^a_i;

  // Reduction/logical results are 1-bit unsigned, so they always zero-extend.
  always_comb begin
    res_o = '0;
    res_o.not_                = ~a_i;
    res_o.not_signed          = ~a_i;
    res_o.not_w               = ~zext6(a_i);
    res_o.not_signed_w        = ~sext6(a_i);
    res_o.neg_                = -a_i;
    res_o.neg_signed          = -a_i;
    res_o.neg_w               = -zext6(a_i);
    res_o.neg_signed_w        = -sext6(a_i);
    res_o.pos_                = a_i;
    res_o.pos_signed          = a_i;
    res_o.pos_w               = zext6(a_i);
    res_o.pos_signed_w        = sext6(a_i);
    res_o.reduce_and_         = {3'b000, andBit};
    res_o.reduce_and_signed   = {3'b000, andBit};
    res_o.reduce_and_bit      = andBit;
    res_o.reduce_or_          = {3'b000, orBit};
    res_o.reduce_or_signed    = {3'b000, orBit};
    res_o.reduce_or_bit       = orBit;
    res_o.reduce_bool_        = {3'b000, orBit};
    res_o.reduce_bool_signed  = {3'b000, orBit};
    res_o.reduce_bool_bit     = orBit;
    res_o.reduce_xor_         = {3'b000, xorBit};
    res_o.reduce_xor_signed   = {3'b000, xorBit};
    res_o.reduce_xor_bit      = xorBit;
    res_o.reduce_xor_bit_bit  = a_i[0];
    res_o.reduce_xnor_        = {3'b000, ~xorBit};
    res_o.reduce_xnor_signed  = {3'b000, ~xorBit};
    res_o.reduce_xnor_bit     = ~xorBit;
    res_o.reduce_xnor_bit_bit = ~a_i[0];
    res_o.logic_not_          = {3'b000, ~orBit};
    res_o.logic_not_signed    = {3'b000, ~orBit};
    res_o.logic_not_bit       = ~orBit;
  end

endmodule

// File: rtl/unary_ops.sv
// Registered unary operator bank: operator core followed by a reset-clearable
// output register, one cycle of latency.
module unary_ops
  import unary_ops_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   a,
  output logic [IN_W-1:0]   not_,
  output logic [IN_W-1:0]   not_signed,
  output logic [WIDE_W-1:0] not_w,
  output logic [WIDE_W-1:0] not_signed_w,
  output logic [IN_W-1:0]   neg_,
  output logic [IN_W-1:0]   neg_signed,
  output logic [WIDE_W-1:0] neg_w,
  output logic [WIDE_W-1:0] neg_signed_w,
  output logic [IN_W-1:0]   pos_,
  output logic [IN_W-1:0]   pos_signed,
  output logic [WIDE_W-1:0] pos_w,
  output logic [WIDE_W-1:0] pos_signed_w,
  output logic [IN_W-1:0]   reduce_and_,
  output logic [IN_W-1:0]   reduce_and_signed,
  output logic              reduce_and_bit,
  output logic [IN_W-1:0]   reduce_or_,
  output logic [IN_W-1:0]   reduce_or_signed,
  output logic              reduce_or_bit,
  output logic [IN_W-1:0]   reduce_bool_,
  output logic [IN_W-1:0]   reduce_bool_signed,
  output logic              reduce_bool_bit,
  output logic [IN_W-1:0]   reduce_xor_,
  output logic [IN_W-1:0]   reduce_xor_signed,
  output logic              reduce_xor_bit,
  output logic              reduce_xor_bit_bit,
  output logic [IN_W-1:0]   reduce_xnor_,
  output logic [IN_W-1:0]   reduce_xnor_signed,
  output logic              reduce_xnor_bit,
  output logic              reduce_xnor_bit_bit,
  output logic [IN_W-1:0]   logic_not_,
  output logic [IN_W-1:0]   logic_not_signed,
  output logic              logic_not_bit
);

  res_t res_d, res_q;

  unary_ops_comb u_comb (
    .a_i   (a),
    .res_o (res_d)
  );

  // Reset clears everything, including outputs that are 1 for a zero operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) res_q <= '0;
    else        res_q <= res_d;
  end

  assign not_                = res_q.not_;
  assign not_signed          = res_q.not_signed;
  assign not_w               = res_q.not_w;
  assign not_signed_w        = res_q.not_signed_w;
  assign neg_                = res_q.neg_;
  assign neg_signed          = res_q.neg_signed;
  assign neg_w               = res_q.neg_w;
  assign neg_signed_w        = res_q.neg_signed_w;
  assign pos_                = res_q.pos_;
  assign pos_signed          = res_q.pos_signed;
  assign pos_w               = res_q.pos_w;
  assign pos_signed_w        = res_q.pos_signed_w;
  assign reduce_and_         = res_q.reduce_and_;
  assign reduce_and_signed   = res_q.reduce_and_signed;
  assign reduce_and_bit      = res_q.reduce_and_bit;
  assign reduce_or_          = res_q.reduce_or_;
  assign reduce_or_signed    = res_q.reduce_or_signed;
  assign reduce_or_bit       = res_q.reduce_or_bit;
  assign reduce_bool_        = res_q.reduce_bool_;
  assign reduce_bool_signed  = res_q.reduce_bool_signed;
  assign reduce_bool_bit     = res_q.reduce_bool_bit;
  assign reduce_xor_         = res_q.reduce_xor_;
  assign reduce_xor_signed   = res_q.reduce_xor_signed;
  assign reduce_xor_bit      = res_q.reduce_xor_bit;
  assign reduce_xor_bit_bit  = res_q.reduce_xor_bit_bit;
  assign reduce_xnor_        = res_q.reduce_xnor_;
  assign reduce_xnor_signed  = res_q.reduce_xnor_signed;
  assign reduce_xnor_bit     = res_q.reduce_xnor_bit;
  assign reduce_xnor_bit_bit = res_q.reduce_xnor_bit_bit;
  assign logic_not_          = res_q.logic_not_;
  assign logic_not_signed    = res_q.logic_not_signed;
  assign logic_not_bit       = res_q.logic_not_bit;

endmodule

// File: tb/tb_unary_ops.sv
// Scoreboard bench for unary_ops: arithmetic reference model, directed
// operand checks, and an xorshift128 sweep with a mid-run reset.
module tb_unary_ops;
  import unary_ops_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;

  logic [3:0] not_, not_signed, neg_, neg_signed, pos_, pos_signed;
  logic [5:0] not_w, not_signed_w, neg_w, neg_signed_w, pos_w, pos_signed_w;
  logic [3:0] reduce_and_, reduce_and_signed, reduce_or_, reduce_or_signed;
  logic [3:0] reduce_bool_, reduce_bool_signed, reduce_xor_, reduce_xor_signed;
  logic [3:0] reduce_xnor_, reduce_xnor_signed, logic_not_, logic_not_signed;
  logic       reduce_and_bit, reduce_or_bit, reduce_bool_bit, reduce_xor_bit;
  logic       reduce_xor_bit_bit, reduce_xnor_bit, reduce_xnor_bit_bit, logic_not_bit;

  int   errors = 0;
  int   checks = 0;
  res_t expQ[$];
  logic [31:0] xsX, xsY, xsZ, xsW;

  unary_ops dut (
    .clk(clk), .rst_n(rst_n), .a(a),
    .not_(not_), .not_signed(not_signed), .not_w(not_w), .not_signed_w(not_signed_w),
    .neg_(neg_), .neg_signed(neg_signed), .neg_w(neg_w), .neg_signed_w(neg_signed_w),
    .pos_(pos_), .pos_signed(pos_signed), .pos_w(pos_w), .pos_signed_w(pos_signed_w),
    .reduce_and_(reduce_and_), .reduce_and_signed(reduce_and_signed),
    .reduce_and_bit(reduce_and_bit),
    .reduce_or_(reduce_or_), .reduce_or_signed(reduce_or_signed),
    .reduce_or_bit(reduce_or_bit),
    .reduce_bool_(reduce_bool_), .reduce_bool_signed(reduce_bool_signed),
    .reduce_bool_bit(reduce_bool_bit),
    .reduce_xor_(reduce_xor_), .reduce_xor_signed(reduce_xor_signed),
    .reduce_xor_bit(reduce_xor_bit), .reduce_xor_bit_bit(reduce_xor_bit_bit),
    .reduce_xnor_(reduce_xnor_), .reduce_xnor_signed(reduce_xnor_signed),
    .reduce_xnor_bit(reduce_xnor_bit), .reduce_xnor_bit_bit(reduce_xnor_bit_bit),
    .logic_not_(logic_not_), .logic_not_signed(logic_not_signed),
    .logic_not_bit(logic_not_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the operand value.
  function automatic res_t refModel(input int v);
    res_t r;
    int s;
    int ones;
    s = (v >= 8) ? v - 16 : v;
    ones = 0;
    for (int i = 0; i < 4; i++) ones += (v >> i) & 1;
    r = '0;
    r.not_                = 4'(15 - v);
    r.not_signed          = 4'(15 - v);
    r.not_w               = 6'(63 - v);
    r.not_signed_w        = 6'((63 - s) % 64);
    r.neg_                = 4'((16 - v) % 16);
    r.neg_signed          = 4'((16 - v) % 16);
    r.neg_w               = 6'((64 - v) % 64);
    r.neg_signed_w        = 6'((64 - s) % 64);
    r.pos_                = 4'(v);
    r.pos_signed          = 4'(v);
    r.pos_w               = 6'(v);
    r.pos_signed_w        = 6'((s + 64) % 64);
    r.reduce_and_         = (v == 15) ? 4'd1 : 4'd0;
    r.reduce_and_signed   = r.reduce_and_;
    r.reduce_and_bit      = (v == 15);
    r.reduce_or_          = (v != 0) ? 4'd1 : 4'd0;
    r.reduce_or_signed    = r.reduce_or_;
    r.reduce_or_bit       = (v != 0);
    r.reduce_bool_        = r.reduce_or_;
    r.reduce_bool_signed  = r.reduce_or_;
    r.reduce_bool_bit     = (v != 0);
    r.reduce_xor_         = 4'(ones % 2);
    r.reduce_xor_signed   = 4'(ones % 2);
    r.reduce_xor_bit      = (ones % 2 == 1);
    r.reduce_xor_bit_bit  = (v % 2 == 1);
    r.reduce_xnor_        = 4'(1 - ones % 2);
    r.reduce_xnor_signed  = 4'(1 - ones % 2);
    r.reduce_xnor_bit     = (ones % 2 == 0);
    r.reduce_xnor_bit_bit = (v % 2 == 0);
    r.logic_not_          = (v == 0) ? 4'd1 : 4'd0;
    r.logic_not_signed    = r.logic_not_;
    r.logic_not_bit       = (v == 0);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [5:0] actual,
                             input logic [5:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compareAll(input string tag, input res_t e);
    checkOutput({tag, " not_"}, 6'(not_), 6'(e.not_));
    checkOutput({tag, " not_signed"}, 6'(not_signed), 6'(e.not_signed));
    checkOutput({tag, " not_w"}, not_w, e.not_w);
    checkOutput({tag, " not_signed_w"}, not_signed_w, e.not_signed_w);
    checkOutput({tag, " neg_"}, 6'(neg_), 6'(e.neg_));
    checkOutput({tag, " neg_signed"}, 6'(neg_signed), 6'(e.neg_signed));
    checkOutput({tag, " neg_w"}, neg_w, e.neg_w);
    checkOutput({tag, " neg_signed_w"}, neg_signed_w, e.neg_signed_w);
    checkOutput({tag, " pos_"}, 6'(pos_), 6'(e.pos_));
    checkOutput({tag, " pos_signed"}, 6'(pos_signed), 6'(e.pos_signed));
    checkOutput({tag, " pos_w"}, pos_w, e.pos_w);
    checkOutput({tag, " pos_signed_w"}, pos_signed_w, e.pos_signed_w);
    checkOutput({tag, " reduce_and_"}, 6'(reduce_and_), 6'(e.reduce_and_));
    checkOutput({tag, " reduce_and_signed"}, 6'(reduce_and_signed), 6'(e.reduce_and_signed));
    checkOutput({tag, " reduce_and_bit"}, 6'(reduce_and_bit), 6'(e.reduce_and_bit));
    checkOutput({tag, " reduce_or_"}, 6'(reduce_or_), 6'(e.reduce_or_));
    checkOutput({tag, " reduce_or_signed"}, 6'(reduce_or_signed), 6'(e.reduce_or_signed));
    checkOutput({tag, " reduce_or_bit"}, 6'(reduce_or_bit), 6'(e.reduce_or_bit));
    checkOutput({tag, " reduce_bool_"}, 6'(reduce_bool_), 6'(e.reduce_bool_));
    checkOutput({tag, " reduce_bool_signed"}, 6'(reduce_bool_signed), 6'(e.reduce_bool_signed));
    checkOutput({tag, " reduce_bool_bit"}, 6'(reduce_bool_bit), 6'(e.reduce_bool_bit));
    checkOutput({tag, " reduce_xor_"}, 6'(reduce_xor_), 6'(e.reduce_xor_));
    checkOutput({tag, " reduce_xor_signed"}, 6'(reduce_xor_signed), 6'(e.reduce_xor_signed));
    checkOutput({tag, " reduce_xor_bit"}, 6'(reduce_xor_bit), 6'(e.reduce_xor_bit));
    checkOutput({tag, " reduce_xor_bit_bit"}, 6'(reduce_xor_bit_bit), 6'(e.reduce_xor_bit_bit));
    checkOutput({tag, " reduce_xnor_"}, 6'(reduce_xnor_), 6'(e.reduce_xnor_));
    checkOutput({tag, " reduce_xnor_signed"}, 6'(reduce_xnor_signed), 6'(e.reduce_xnor_signed));
    checkOutput({tag, " reduce_xnor_bit"}, 6'(reduce_xnor_bit), 6'(e.reduce_xnor_bit));
    checkOutput({tag, " reduce_xnor_bit_bit"}, 6'(reduce_xnor_bit_bit), 6'(e.reduce_xnor_bit_bit));
    checkOutput({tag, " logic_not_"}, 6'(logic_not_), 6'(e.logic_not_));
    checkOutput({tag, " logic_not_signed"}, 6'(logic_not_signed), 6'(e.logic_not_signed));
    checkOutput({tag, " logic_not_bit"}, 6'(logic_not_bit), 6'(e.logic_not_bit));
  endtask

  // Drive one operand on the falling edge and queue its expected response.
  task automatic applyStimulus(input logic [3:0] v);
    @(negedge clk);
    rst_n = 1'b1;
    a = v;
    expQ.push_back(refModel(int'(v)));
  endtask

  function automatic logic [3:0] xorshiftNext();
    logic [31:0] t;
    t   = xsX ^ (xsX << 11);
    xsX = xsY;
    xsY = xsZ;
    xsZ = xsW;
    xsW = xsW ^ (xsW >> 19) ^ (t ^ (t >> 8));
    return xsW[3:0];
  endfunction

  // Monitor: the register updates every edge, so each edge either shows
  // all-zero (in reset) or the response to the oldest queued operand.
  always @(posedge clk) begin
    #1;
    if (!rst_n) compareAll("reset", '0);
    else if (expQ.size() > 0) compareAll("model", expQ.pop_front());
  end

  initial begin
    int resetAt;
    rst_n = 1'b0;
    a = 4'b1111;
    xsX = 32'd1652613690;
    xsY = 32'd362436069;
    xsZ = 32'd521288629;
    xsW = 32'd88675123;
    repeat (3) @(posedge clk);

    applyStimulus(4'b1111);
    @(posedge clk); #2;
    checkOutput("d1111 neg_", 6'(neg_), 6'b000001);
    checkOutput("d1111 neg_w", neg_w, 6'b110001);
    checkOutput("d1111 neg_signed_w", neg_signed_w, 6'b000001);
    checkOutput("d1111 not_w", not_w, 6'b110000);
    checkOutput("d1111 not_signed_w", not_signed_w, 6'b000000);
    checkOutput("d1111 pos_w", pos_w, 6'b001111);
    checkOutput("d1111 pos_signed_w", pos_signed_w, 6'b111111);
    checkOutput("d1111 reduce_and_", 6'(reduce_and_), 6'b000001);
    checkOutput("d1111 reduce_xor_bit", 6'(reduce_xor_bit), 6'd0);
    checkOutput("d1111 reduce_xnor_bit", 6'(reduce_xnor_bit), 6'd1);

    applyStimulus(4'b0000);
    @(posedge clk); #2;
    checkOutput("d0000 not_", 6'(not_), 6'b001111);
    checkOutput("d0000 not_w", not_w, 6'b111111);
    checkOutput("d0000 not_signed_w", not_signed_w, 6'b111111);
    checkOutput("d0000 neg_w", neg_w, 6'd0);
    checkOutput("d0000 neg_signed_w", neg_signed_w, 6'd0);
    checkOutput("d0000 logic_not_", 6'(logic_not_), 6'b000001);
    checkOutput("d0000 reduce_xnor_", 6'(reduce_xnor_), 6'b000001);
    checkOutput("d0000 reduce_or_bit", 6'(reduce_or_bit), 6'd0);

    applyStimulus(4'b1000);
    @(posedge clk); #2;
    checkOutput("d1000 neg_", 6'(neg_), 6'b001000);
    checkOutput("d1000 neg_w", neg_w, 6'b111000);
    checkOutput("d1000 neg_signed_w", neg_signed_w, 6'b001000);
    checkOutput("d1000 pos_signed_w", pos_signed_w, 6'b111000);
    checkOutput("d1000 not_w", not_w, 6'b110111);
    checkOutput("d1000 not_signed_w", not_signed_w, 6'b000111);
    checkOutput("d1000 reduce_xor_", 6'(reduce_xor_), 6'b000001);
    checkOutput("d1000 reduce_and_", 6'(reduce_and_), 6'd0);
    checkOutput("d1000 logic_not_bit", 6'(logic_not_bit), 6'd0);

    applyStimulus(4'b0101);
    @(posedge clk); #2;
    checkOutput("d0101 reduce_xor_bit", 6'(reduce_xor_bit), 6'd0);
    checkOutput("d0101 reduce_xor_bit_bit", 6'(reduce_xor_bit_bit), 6'd1);
    checkOutput("d0101 reduce_xnor_bit_bit", 6'(reduce_xnor_bit_bit), 6'd0);
    checkOutput("d0101 reduce_bool_", 6'(reduce_bool_), 6'b000001);
    checkOutput("d0101 not_", 6'(not_), 6'b001010);

    resetAt = int'($urandom_range(300, 700));
    for (int i = 0; i < 1000; i++) begin
      if (i == resetAt) begin
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        compareAll("async", '0);
        repeat (2) @(posedge clk);
      end
      applyStimulus(xorshiftNext());
    end

    repeat (2) @(posedge clk);
    #3;
    checkOutput("queue drained", 6'(expQ.size()), 6'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
